// File: rtl/wb_commit_stage_pkg.sv
// rtl/wb_commit_stage_pkg.sv - shared CP0 addresses, exception codes and field positions
package wb_commit_stage_pkg;

   localparam logic [7:0] CP0_BADVADDR = 8'h40;
   localparam logic [7:0] CP0_COUNT    = 8'h48;
   localparam logic [7:0] CP0_COMPARE  = 8'h58;
   localparam logic [7:0] CP0_STATUS   = 8'h60;
   localparam logic [7:0] CP0_CAUSE    = 8'h68;
   localparam logic [7:0] CP0_EPC      = 8'h70;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

   localparam int STATUS_BEV    = 22;
   localparam int STATUS_IM_LSB = 8;
   localparam int STATUS_EXL    = 1;
   localparam int STATUS_IE     = 0;
   localparam int CAUSE_BD      = 31;
   localparam int CAUSE_TI      = 30;
   localparam int CAUSE_IP_LSB  = 8;
   localparam int CAUSE_EXC_LSB = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [3:0]  gr_we;
      logic [4:0]  dest;
      logic [31:0] result;
      logic        exc;
      logic [4:0]  exc_code;
      logic [31:0] badvaddr;
      logic        bd;
      logic        eret;
      logic        mtc0;
      logic        mfc0;
      logic [7:0]  cp0_addr;
   } ws_inst_t;

   // Only address-error exceptions capture the faulting address.
   function automatic logic is_addr_exc(input logic [4:0] code);
      return (code == EXC_ADEL) || (code == EXC_ADES);
   endfunction

endpackage

// File: rtl/wb_commit_stage_cp0_regfile.sv
// rtl/wb_commit_stage_cp0_regfile.sv - CP0 state: Status, Cause, EPC, BadVAddr, Count/Compare timer
module cp0_regfile
   import wb_commit_stage_pkg::*;
#(
   parameter int HW_INT_NUM = 6,
   parameter int COUNT_DIV  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [HW_INT_NUM-1:0] i_hw_int,
   input  logic                  i_mtc0_we,
   input  logic [7:0]            i_addr,
   input  logic [31:0]           i_wdata,
   input  logic                  i_exc,
   input  logic [4:0]            i_exc_code,
   input  logic [31:0]           i_exc_pc,
   input  logic                  i_exc_bd,
   input  logic [31:0]           i_exc_badvaddr,
   input  logic                  i_eret,
   output logic [31:0]           o_rdata,
   output logic [31:0]           o_epc,
   output logic                  o_int_req
);

   logic [31:0] r_badvaddr;
   logic [31:0] r_count;
   logic [31:0] r_compare;
   logic [31:0] r_epc;
   logic [7:0]  r_status_im;
   logic        r_status_exl;
   logic        r_status_ie;
   logic        r_cause_bd;
   logic        r_cause_ti;
   logic [5:0]  r_cause_ip_hw;
   logic [1:0]  r_cause_ip_sw;
   logic [4:0]  r_cause_exc;
   logic        r_div;

   logic [5:0]  w_hw_ext;
   logic [7:0]  w_cause_ip;
   logic        w_tick;
   logic        w_wr_count;
   logic        w_wr_compare;
   logic        w_wr_status;
   logic        w_wr_cause;
   logic        w_wr_epc;
   logic [31:0] w_status;
   logic [31:0] w_cause;

   always_comb begin
      w_hw_ext = '0;
      w_hw_ext[HW_INT_NUM-1:0] = i_hw_int;
   end

   // Timer interrupt shares IP[7] with the highest hardware line.
   assign w_cause_ip = {r_cause_ip_hw[5] | r_cause_ti, r_cause_ip_hw[4:0], r_cause_ip_sw};
   assign o_int_req  = r_status_ie & ~r_status_exl & (|(w_cause_ip & r_status_im));
   assign o_epc      = r_epc;
   assign w_tick     = (COUNT_DIV == 1) || r_div;

   assign w_wr_count   = i_mtc0_we && (i_addr == CP0_COUNT);
   assign w_wr_compare = i_mtc0_we && (i_addr == CP0_COMPARE);
   assign w_wr_status  = i_mtc0_we && (i_addr == CP0_STATUS);
   assign w_wr_cause   = i_mtc0_we && (i_addr == CP0_CAUSE);
   assign w_wr_epc     = i_mtc0_we && (i_addr == CP0_EPC);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_badvaddr    <= '0;
         r_count       <= '0;
         r_compare     <= '0;
         r_epc         <= '0;
         r_status_im   <= '0;
         r_status_exl  <= 1'b0;
         r_status_ie   <= 1'b0;
         r_cause_bd    <= 1'b0;
         r_cause_ti    <= 1'b0;
         r_cause_ip_hw <= '0;
         r_cause_ip_sw <= '0;
         r_cause_exc   <= '0;
         r_div         <= 1'b0;
      end else begin
         r_cause_ip_hw <= w_hw_ext;

         if (w_wr_count) begin
            r_count <= i_wdata;
            r_div   <= 1'b0;
         end else begin
            if (w_tick) r_count <= r_count + 32'd1;
            r_div <= (COUNT_DIV == 1) ? 1'b0 : ~r_div;
         end

         if (w_wr_compare) begin
            r_compare  <= i_wdata;
            r_cause_ti <= 1'b0;
         end else if (r_count == r_compare) begin
            r_cause_ti <= 1'b1;
         end

         if (w_wr_status) begin
            r_status_im  <= i_wdata[STATUS_IM_LSB +: 8];
            r_status_exl <= i_wdata[STATUS_EXL];
            r_status_ie  <= i_wdata[STATUS_IE];
         end
         if (w_wr_cause) r_cause_ip_sw <= i_wdata[CAUSE_IP_LSB +: 2];
         if (w_wr_epc)   r_epc <= i_wdata;

         // A nested exception keeps the original return point.
         if (i_exc) begin
            if (!r_status_exl) begin
               r_epc      <= i_exc_bd ? i_exc_pc - 32'd4 : i_exc_pc;
               r_cause_bd <= i_exc_bd;
            end
            r_status_exl <= 1'b1;
            r_cause_exc  <= i_exc_code;
            if (is_addr_exc(i_exc_code)) r_badvaddr <= i_exc_badvaddr;
         end else if (i_eret) begin
            r_status_exl <= 1'b0;
         end
      end
   end

   always_comb begin
      w_status = '0;
      w_status[STATUS_BEV] = 1'b1;
      w_status[STATUS_IM_LSB +: 8] = r_status_im;
      w_status[STATUS_EXL] = r_status_exl;
      w_status[STATUS_IE] = r_status_ie;
      w_cause = '0;
      w_cause[CAUSE_BD] = r_cause_bd;
      w_cause[CAUSE_TI] = r_cause_ti;
      w_cause[CAUSE_IP_LSB +: 8] = w_cause_ip;
      w_cause[CAUSE_EXC_LSB +: 5] = r_cause_exc;
   end

   always_comb begin
      o_rdata = '0;
      case (i_addr)
         CP0_BADVADDR: o_rdata = r_badvaddr;
         CP0_COUNT:    o_rdata = r_count;
         CP0_COMPARE:  o_rdata = r_compare;
         CP0_STATUS:   o_rdata = w_status;
         CP0_CAUSE:    o_rdata = w_cause;
         CP0_EPC:      o_rdata = r_epc;
         default:      o_rdata = '0;
      endcase
   end

endmodule

// File: rtl/wb_commit_stage.sv
// rtl/wb_commit_stage.sv - write-back stage: pipeline latch, exception/eret arbitration, flush, GPR write
module wb_commit_stage
   import wb_commit_stage_pkg::*;
#(
   parameter int          HW_INT_NUM = 6,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
   parameter int          COUNT_DIV  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  ms_to_ws_valid,
   output logic                  ws_allowin,
   input  logic [31:0]           ms_pc,
   input  logic [3:0]            ms_gr_we,
   input  logic [4:0]            ms_dest,
   input  logic [31:0]           ms_result,
   input  logic                  ms_exc,
   input  logic [4:0]            ms_exc_code,
   input  logic [31:0]           ms_badvaddr,
   input  logic                  ms_bd,
   input  logic                  ms_eret,
   input  logic                  ms_mtc0,
   input  logic                  ms_mfc0,
   input  logic [7:0]            ms_cp0_addr,
   input  logic [HW_INT_NUM-1:0] hw_int,
   output logic [3:0]            rf_we,
   output logic [4:0]            rf_waddr,
   output logic [31:0]           rf_wdata,
   output logic                  ws_flush,
   output logic [31:0]           ws_flush_pc,
   output logic [5:0]            ws_busy_dest,
   output logic [31:0]           debug_wb_pc,
   output logic [3:0]            debug_wb_rf_wen,
   output logic [4:0]            debug_wb_rf_wnum,
   output logic [31:0]           debug_wb_rf_wdata
);

   ws_inst_t    r_ws;
   logic        r_ws_valid;

   logic        w_live;
   logic        w_int_req;
   logic        w_exc;
   logic [4:0]  w_exc_code;
   logic        w_eret;
   logic        w_mtc0;
   logic [31:0] w_epc;
   logic [31:0] w_cp0_rdata;

   assign ws_allowin = 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ws_valid <= 1'b0;
         r_ws       <= '0;
      end else begin
         r_ws_valid <= ms_to_ws_valid && ws_allowin && !ws_flush;
         if (ms_to_ws_valid && ws_allowin) begin
            r_ws <= '{pc: ms_pc, gr_we: ms_gr_we, dest: ms_dest, result: ms_result,
                      exc: ms_exc, exc_code: ms_exc_code, badvaddr: ms_badvaddr,
                      bd: ms_bd, eret: ms_eret, mtc0: ms_mtc0, mfc0: ms_mfc0,
                      cp0_addr: ms_cp0_addr};
         end
      end
   end

   // Reset discards the resident instruction even in the cycle it is asserted.
   assign w_live     = r_ws_valid & ~reset;
   assign w_exc      = w_live & (w_int_req | r_ws.exc);
   assign w_exc_code = w_int_req ? EXC_INT : r_ws.exc_code;
   assign w_eret     = w_live & r_ws.eret & ~w_exc;
   assign w_mtc0     = w_live & r_ws.mtc0 & ~w_exc;

   assign ws_flush     = w_exc | w_eret;
   assign ws_flush_pc  = w_exc ? EXC_VECTOR : w_epc;
   assign rf_we        = r_ws.gr_we & {4{w_live & ~w_exc}};
   assign rf_waddr     = r_ws.dest;
   assign rf_wdata     = r_ws.mfc0 ? w_cp0_rdata : r_ws.result;
   assign ws_busy_dest = {w_live & (|r_ws.gr_we), r_ws.dest};

   assign debug_wb_pc       = r_ws.pc;
   assign debug_wb_rf_wen   = rf_we;
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;

   cp0_regfile #(
      .HW_INT_NUM(HW_INT_NUM),
      .COUNT_DIV (COUNT_DIV)
   ) u_cp0 (
      .clk           (clk),
      .reset         (reset),
      .i_hw_int      (hw_int),
      .i_mtc0_we     (w_mtc0),
      .i_addr        (r_ws.cp0_addr),
      .i_wdata       (r_ws.result),
      .i_exc         (w_exc),
      .i_exc_code    (w_exc_code),
      .i_exc_pc      (r_ws.pc),
      .i_exc_bd      (r_ws.bd),
      .i_exc_badvaddr(r_ws.badvaddr),
      .i_eret        (w_eret),
      .o_rdata       (w_cp0_rdata),
      .o_epc         (w_epc),
      .o_int_req     (w_int_req)
   );

endmodule

// File: tb/tb_wb_commit_stage.sv
// tb/tb_wb_commit_stage.sv - directed self-checking bench for wb_commit_stage
module tb_wb_commit_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        ms_to_ws_valid;
   logic        ws_allowin;
   logic [31:0] ms_pc;
   logic [3:0]  ms_gr_we;
   logic [4:0]  ms_dest;
   logic [31:0] ms_result;
   logic        ms_exc;
   logic [4:0]  ms_exc_code;
   logic [31:0] ms_badvaddr;
   logic        ms_bd;
   logic        ms_eret;
   logic        ms_mtc0;
   logic        ms_mfc0;
   logic [7:0]  ms_cp0_addr;
   logic [5:0]  hw_int;
   logic [3:0]  rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        ws_flush;
   logic [31:0] ws_flush_pc;
   logic [5:0]  ws_busy_dest;
   logic [31:0] debug_wb_pc;
   logic [3:0]  debug_wb_rf_wen;
   logic [4:0]  debug_wb_rf_wnum;
   logic [31:0] debug_wb_rf_wdata;

   int checks = 0;
   int failures = 0;

   localparam logic [7:0] A_BADV = 8'h40;
   localparam logic [7:0] A_CNT  = 8'h48;
   localparam logic [7:0] A_CMP  = 8'h58;
   localparam logic [7:0] A_STS  = 8'h60;
   localparam logic [7:0] A_CAU  = 8'h68;
   localparam logic [7:0] A_EPC  = 8'h70;

   always #5 clk = ~clk;

   wb_commit_stage dut (
      .clk(clk), .reset(reset), .ms_to_ws_valid(ms_to_ws_valid), .ws_allowin(ws_allowin),
      .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result),
      .ms_exc(ms_exc), .ms_exc_code(ms_exc_code), .ms_badvaddr(ms_badvaddr), .ms_bd(ms_bd),
      .ms_eret(ms_eret), .ms_mtc0(ms_mtc0), .ms_mfc0(ms_mfc0), .ms_cp0_addr(ms_cp0_addr),
      .hw_int(hw_int), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .ws_flush(ws_flush), .ws_flush_pc(ws_flush_pc), .ws_busy_dest(ws_busy_dest),
      .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
   );

   task automatic clr_ms();
      ms_pc = '0; ms_gr_we = '0; ms_dest = '0; ms_result = '0; ms_exc = 1'b0;
      ms_exc_code = '0; ms_badvaddr = '0; ms_bd = 1'b0; ms_eret = 1'b0;
      ms_mtc0 = 1'b0; ms_mfc0 = 1'b0; ms_cp0_addr = '0;
   endtask

   // One idle edge retires whatever is in WB, then the next edge loads the new instruction.
   task automatic issue();
      @(posedge clk);
      @(negedge clk);
      ms_to_ws_valid = 1'b1;
      @(posedge clk);
      #1;
      ms_to_ws_valid = 1'b0;
   endtask

   task automatic do_mtc0(input logic [7:0] a, input logic [31:0] d);
      clr_ms(); ms_mtc0 = 1'b1; ms_cp0_addr = a; ms_result = d; ms_pc = 32'h8000_1000;
      issue();
   endtask

   task automatic do_mfc0(input logic [7:0] a);
      clr_ms(); ms_mfc0 = 1'b1; ms_gr_we = 4'hF; ms_dest = 5'd8; ms_cp0_addr = a;
      ms_pc = 32'h8000_2000; issue();
   endtask

   task automatic test_reset();
      clr_ms(); ms_to_ws_valid = 1'b0; hw_int = '0; reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (ws_flush !== 1'b0) begin failures++; $display("FAIL reset_flush got %b exp 0", ws_flush); end
      checks++; if (rf_we !== 4'h0) begin failures++; $display("FAIL reset_rf_we got %h exp 0", rf_we); end
      checks++; if (ws_busy_dest !== 6'h00) begin failures++; $display("FAIL reset_busy got %h exp 00", ws_busy_dest); end
      checks++; if (ws_allowin !== 1'b1) begin failures++; $display("FAIL allowin got %b exp 1", ws_allowin); end
      @(negedge clk); reset = 1'b0;
      do_mfc0(A_STS);
      checks++; if (rf_wdata !== 32'h0040_0000) begin failures++; $display("FAIL reset_status got %h exp 00400000", rf_wdata); end
      do_mfc0(A_EPC);
      checks++; if (rf_wdata !== 32'h0) begin failures++; $display("FAIL reset_epc got %h exp 0", rf_wdata); end
      do_mfc0(A_BADV);
      checks++; if (rf_wdata !== 32'h0) begin failures++; $display("FAIL reset_badv got %h exp 0", rf_wdata); end
      do_mfc0(A_CMP);
      checks++; if (rf_wdata !== 32'h0) begin failures++; $display("FAIL reset_compare got %h exp 0", rf_wdata); end
      // Count==Compare==0 right after reset, so TI (and IP7) is already up.
      do_mfc0(A_CAU);
      checks++; if (rf_wdata !== 32'h4000_8000) begin failures++; $display("FAIL reset_cause got %h exp 40008000", rf_wdata); end
      do_mtc0(A_CMP, 32'h7FFF_0000);
      do_mfc0(A_CAU);
      checks++; if (rf_wdata !== 32'h0) begin failures++; $display("FAIL cause_ti_clr got %h exp 0", rf_wdata); end
   endtask

   task automatic test_plain_write();
      clr_ms(); ms_pc = 32'h8000_0000; ms_gr_we = 4'h3; ms_dest = 5'd5; ms_result = 32'hCAFE_F00D;
      issue();
      checks++; if (rf_we !== 4'h3) begin failures++; $display("FAIL add_rf_we got %h exp 3", rf_we); end
      checks++; if (rf_waddr !== 5'd5) begin failures++; $display("FAIL add_waddr got %0d exp 5", rf_waddr); end
      checks++; if (rf_wdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL add_wdata got %h exp cafef00d", rf_wdata); end
      checks++; if (ws_flush !== 1'b0) begin failures++; $display("FAIL add_flush got %b exp 0", ws_flush); end
      checks++; if (ws_busy_dest !== 6'h25) begin failures++; $display("FAIL add_busy got %h exp 25", ws_busy_dest); end
      checks++; if (debug_wb_pc !== 32'h8000_0000) begin failures++; $display("FAIL add_dbg_pc got %h exp 80000000", debug_wb_pc); end
      checks++; if (debug_wb_rf_wen !== 4'h3) begin failures++; $display("FAIL add_dbg_wen got %h exp 3", debug_wb_rf_wen); end
   endtask

   task automatic test_interrupt();
      hw_int = 6'b000001;
      do_mtc0(A_STS, 32'h0000_0401);
      clr_ms(); ms_pc = 32'h8000_0100; ms_gr_we = 4'hF; ms_dest = 5'd3; ms_result = 32'd123;
      issue();
      checks++; if (ws_flush !== 1'b1) begin failures++; $display("FAIL int_flush got %b exp 1", ws_flush); end
      checks++; if (ws_flush_pc !== 32'hBFC0_0380) begin failures++; $display("FAIL int_flush_pc got %h exp bfc00380", ws_flush_pc); end
      checks++; if (rf_we !== 4'h0) begin failures++; $display("FAIL int_rf_we got %h exp 0", rf_we); end
      checks++; if (ws_busy_dest !== 6'h23) begin failures++; $display("FAIL int_busy got %h exp 23", ws_busy_dest); end
      hw_int = '0;
      do_mfc0(A_EPC);
      checks++; if (rf_wdata !== 32'h8000_0100) begin failures++; $display("FAIL int_epc got %h exp 80000100", rf_wdata); end
      do_mfc0(A_CAU);
      checks++; if (rf_wdata !== 32'h0) begin failures++; $display("FAIL int_cause got %h exp 0", rf_wdata); end
      do_mfc0(A_STS);
      checks++; if (rf_wdata !== 32'h0040_0403) begin failures++; $display("FAIL int_status got %h exp 00400403", rf_wdata); end
   endtask

   task automatic test_exception();
      clr_ms(); ms_eret = 1'b1; ms_pc = 32'h8000_0300;
      issue();
      checks++; if (ws_flush !== 1'b1) begin failures++; $display("FAIL eret1_flush got %b exp 1", ws_flush); end
      checks++; if (ws_flush_pc !== 32'h8000_0100) begin failures++; $display("FAIL eret1_pc got %h exp 80000100", ws_flush_pc); end
      do_mtc0(A_STS, 32'h0);
      clr_ms(); ms_exc = 1'b1; ms_exc_code = 5'd4; ms_badvaddr = 32'h0000_1001; ms_bd = 1'b1;
      ms_pc = 32'h8000_0010; ms_gr_we = 4'hF; ms_dest = 5'd4;
      issue();
      checks++; if (ws_flush !== 1'b1) begin failures++; $display("FAIL adel_flush got %b exp 1", ws_flush); end
      checks++; if (ws_flush_pc !== 32'hBFC0_0380) begin failures++; $display("FAIL adel_pc got %h exp bfc00380", ws_flush_pc); end
      checks++; if (rf_we !== 4'h0) begin failures++; $display("FAIL adel_rf_we got %h exp 0", rf_we); end
      do_mfc0(A_BADV);
      checks++; if (rf_wdata !== 32'h0000_1001) begin failures++; $display("FAIL adel_badv got %h exp 00001001", rf_wdata); end
      do_mfc0(A_EPC);
      checks++; if (rf_wdata !== 32'h8000_000C) begin failures++; $display("FAIL adel_epc got %h exp 8000000c", rf_wdata); end
      do_mfc0(A_CAU);
      checks++; if (rf_wdata !== 32'h8000_0010) begin failures++; $display("FAIL adel_cause got %h exp 80000010", rf_wdata); end
      do_mfc0(A_STS);
      checks++; if (rf_wdata !== 32'h0040_0002) begin failures++; $display("FAIL adel_status got %h exp 00400002", rf_wdata); end
      clr_ms(); ms_exc = 1'b1; ms_exc_code = 5'd5; ms_badvaddr = 32'h0000_2002; ms_pc = 32'h8000_0200;
      issue();
      checks++; if (ws_flush !== 1'b1) begin failures++; $display("FAIL ades_flush got %b exp 1", ws_flush); end
      do_mfc0(A_EPC);
      checks++; if (rf_wdata !== 32'h8000_000C) begin failures++; $display("FAIL nested_epc got %h exp 8000000c", rf_wdata); end
      do_mfc0(A_BADV);
      checks++; if (rf_wdata !== 32'h0000_2002) begin failures++; $display("FAIL ades_badv got %h exp 00002002", rf_wdata); end
      do_mfc0(A_CAU);
      checks++; if (rf_wdata !== 32'h8000_0014) begin failures++; $display("FAIL nested_cause got %h exp 80000014", rf_wdata); end
      clr_ms(); ms_eret = 1'b1; ms_pc = 32'h8000_0400;
      issue();
      checks++; if (ws_flush !== 1'b1) begin failures++; $display("FAIL eret2_flush got %b exp 1", ws_flush); end
      checks++; if (ws_flush_pc !== 32'h8000_000C) begin failures++; $display("FAIL eret2_pc got %h exp 8000000c", ws_flush_pc); end
      do_mfc0(A_STS);
      checks++; if (rf_wdata !== 32'h0040_0000) begin failures++; $display("FAIL eret2_status got %h exp 00400000", rf_wdata); end
   endtask

   task automatic test_eret_int();
      hw_int = 6'b000001;
      do_mtc0(A_STS, 32'h0000_0401);
      clr_ms(); ms_eret = 1'b1; ms_pc = 32'h8000_0500;
      issue();
      checks++; if (ws_flush_pc !== 32'hBFC0_0380) begin failures++; $display("FAIL eret_int_pc got %h exp bfc00380", ws_flush_pc); end
      hw_int = '0;
      do_mfc0(A_STS);
      checks++; if (rf_wdata !== 32'h0040_0403) begin failures++; $display("FAIL eret_int_status got %h exp 00400403", rf_wdata); end
      do_mfc0(A_EPC);
      checks++; if (rf_wdata !== 32'h8000_0500) begin failures++; $display("FAIL eret_int_epc got %h exp 80000500", rf_wdata); end
      do_mfc0(A_CAU);
      checks++; if (rf_wdata !== 32'h0) begin failures++; $display("FAIL eret_int_cause got %h exp 0", rf_wdata); end
      clr_ms(); ms_eret = 1'b1; ms_pc = 32'h8000_0600;
      issue();
      checks++; if (ws_flush_pc !== 32'h8000_0500) begin failures++; $display("FAIL eret3_pc got %h exp 80000500", ws_flush_pc); end
      do_mtc0(A_STS, 32'h0);
   endtask

   task automatic test_count();
      do_mtc0(A_CMP, 32'h0);
      do_mtc0(A_CNT, 32'hFFFF_FFFE);
      do_mfc0(A_CNT);
      checks++; if (rf_we !== 4'hF) begin failures++; $display("FAIL mfc0_rf_we got %h exp f", rf_we); end
      checks++; if (rf_waddr !== 5'd8) begin failures++; $display("FAIL mfc0_waddr got %0d exp 8", rf_waddr); end
      checks++; if (rf_wdata !== 32'hFFFF_FFFE) begin failures++; $display("FAIL count0 got %h exp fffffffe", rf_wdata); end
      do_mfc0(A_CNT);
      checks++; if (rf_wdata !== 32'hFFFF_FFFF) begin failures++; $display("FAIL count1 got %h exp ffffffff", rf_wdata); end
      do_mfc0(A_CNT);
      checks++; if (rf_wdata !== 32'h0) begin failures++; $display("FAIL count_wrap got %h exp 0", rf_wdata); end
      do_mfc0(A_CAU);
      checks++; if (rf_wdata !== 32'h4000_8000) begin failures++; $display("FAIL timer_cause got %h exp 40008000", rf_wdata); end
      do_mtc0(A_CMP, 32'h7FFF_0000);
      do_mfc0(A_CAU);
      checks++; if (rf_wdata !== 32'h0) begin failures++; $display("FAIL timer_clr got %h exp 0", rf_wdata); end
   endtask

   task automatic test_reset_mid();
      do_mtc0(A_EPC, 32'h1234_5678);
      do_mfc0(A_EPC);
      checks++; if (rf_wdata !== 32'h1234_5678) begin failures++; $display("FAIL epc_rw got %h exp 12345678", rf_wdata); end
      clr_ms(); ms_mtc0 = 1'b1; ms_cp0_addr = A_EPC; ms_result = 32'hDEAD_BEEF; ms_pc = 32'h8000_0700;
      issue();
      reset = 1'b1;
      #1;
      checks++; if (ws_flush !== 1'b0) begin failures++; $display("FAIL rst_mid_flush0 got %b exp 0", ws_flush); end
      @(posedge clk);
      #1;
      checks++; if (ws_flush !== 1'b0) begin failures++; $display("FAIL rst_mid_flush got %b exp 0", ws_flush); end
      checks++; if (rf_we !== 4'h0) begin failures++; $display("FAIL rst_mid_rf_we got %h exp 0", rf_we); end
      checks++; if (ws_busy_dest !== 6'h00) begin failures++; $display("FAIL rst_mid_busy got %h exp 00", ws_busy_dest); end
      @(negedge clk); reset = 1'b0;
      do_mfc0(A_EPC);
      checks++; if (rf_wdata !== 32'h0) begin failures++; $display("FAIL rst_mid_epc got %h exp 0", rf_wdata); end
   endtask

   initial begin
      test_reset();
      test_plain_write();
      test_interrupt();
      test_exception();
      test_eret_int();
      test_count();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
